// File: rtl/pss_multi_peak_detector.sv
// rtl/pss_multi_peak_detector.sv - multi-channel windowed PSS peak detector with adaptive threshold
//
// Combines N_CH correlator magnitudes per sample (max, lowest channel wins
// ties) and reports the strongest local maximum that dominates a
// +/-WINDOW_LEN neighbourhood, exceeds a moving-average-scaled threshold
// and meets an absolute floor. A holdoff suppresses re-triggering.
//
// Ports:
//   clk_i             clock, rising edge
//   reset_ni          synchronous active-low reset
//   s_axis_in_tdata   N_CH unsigned magnitudes, channel c at [c*IN_DW +: IN_DW]
//   s_axis_in_tvalid  sample strobe, no backpressure
//   min_thresh_i      absolute detection floor
//   peak_detected_o   one-cycle detection pulse
//   peak_nid2_o       winning channel index
//   peak_value_o      magnitude at the peak
//   peak_timestamp_o  accepted-sample index of the peak
module pss_multi_peak_detector #(
  parameter int IN_DW        = 32,
  parameter int N_CH         = 3,
  parameter int WINDOW_LEN   = 8,
  parameter int AVG_LEN_LOG2 = 6,
  parameter int THRESH_SHIFT = 3,
  parameter int HOLDOFF      = 64,
  parameter int CNT_DW       = 32,
  localparam int NID_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic [N_CH*IN_DW-1:0]  s_axis_in_tdata,
  input  logic                   s_axis_in_tvalid,
  input  logic [IN_DW-1:0]       min_thresh_i,
  output logic                   peak_detected_o,
  output logic [NID_W-1:0]       peak_nid2_o,
  output logic [IN_DW-1:0]       peak_value_o,
  output logic [CNT_DW-1:0]      peak_timestamp_o
);

  localparam int L      = 2 * WINDOW_LEN + 1;
  localparam int AVG_N  = 1 << AVG_LEN_LOG2;
  localparam int N_FILL = (L > AVG_N) ? L : AVG_N;
  localparam int FILL_W = $clog2(N_FILL + 1);
  localparam int HO_W   = $clog2(HOLDOFF + 1);
  localparam int SUM_W  = IN_DW + AVG_LEN_LOG2;
  localparam int TH_W   = IN_DW + THRESH_SHIFT;

  localparam logic [1:0] ST_FILL   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  // Channel combining: strict '>' keeps the lowest index on ties.
  logic [IN_DW-1:0] comb_val;
  logic [NID_W-1:0] comb_ch;

  always_comb begin
    comb_val = s_axis_in_tdata[0 +: IN_DW];
    comb_ch  = '0;
    for (int c = 1; c < N_CH; c++) begin
      if (s_axis_in_tdata[c*IN_DW +: IN_DW] > comb_val) begin
        comb_val = s_axis_in_tdata[c*IN_DW +: IN_DW];
        comb_ch  = NID_W'(c);
      end
    end
  end

  // History: index 0 is newest, WINDOW_LEN is the candidate, L-1 oldest.
  logic [IN_DW-1:0]  hist_val_q [L];
  logic [NID_W-1:0]  hist_ch_q  [L];
  logic [CNT_DW-1:0] hist_ts_q  [L];
  logic [IN_DW-1:0]  dly_q      [AVG_N];
  logic [SUM_W-1:0]  sum_q;
  logic [CNT_DW-1:0] sample_cnt_q;
  logic [FILL_W-1:0] fill_cnt_q;
  logic              shifted_q;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      for (int i = 0; i < L; i++) begin
        hist_val_q[i] <= '0;
        hist_ch_q[i]  <= '0;
        hist_ts_q[i]  <= '0;
      end
      for (int i = 0; i < AVG_N; i++) begin
        dly_q[i] <= '0;
      end
      sum_q        <= '0;
      sample_cnt_q <= '0;
      fill_cnt_q   <= '0;
      shifted_q    <= 1'b0;
    end else begin
      shifted_q <= s_axis_in_tvalid;
      if (s_axis_in_tvalid) begin
        hist_val_q[0] <= comb_val;
        hist_ch_q[0]  <= comb_ch;
        hist_ts_q[0]  <= sample_cnt_q;
        for (int i = 1; i < L; i++) begin
          hist_val_q[i] <= hist_val_q[i-1];
          hist_ch_q[i]  <= hist_ch_q[i-1];
          hist_ts_q[i]  <= hist_ts_q[i-1];
        end
        dly_q[0] <= comb_val;
        for (int i = 1; i < AVG_N; i++) begin
          dly_q[i] <= dly_q[i-1];
        end
        // Running sum over the last AVG_N values: add newest, drop the one leaving the line.
        sum_q        <= sum_q + SUM_W'(comb_val) - SUM_W'(dly_q[AVG_N-1]);
        sample_cnt_q <= sample_cnt_q + CNT_DW'(1);
        if (fill_cnt_q != FILL_W'(N_FILL)) begin
          fill_cnt_q <= fill_cnt_q + FILL_W'(1);
        end
      end
    end
  end

  // Peak condition on the current history; only acted on when shifted_q says
  // this history state is the result of a fresh accepted sample.
  logic [IN_DW-1:0] center;
  logic [TH_W-1:0]  thresh_base;
  logic [TH_W-1:0]  thresh;
  logic             is_peak;

  always_comb begin
    center      = hist_val_q[WINDOW_LEN];
    thresh_base = TH_W'(sum_q >> AVG_LEN_LOG2);
    thresh      = thresh_base << THRESH_SHIFT;
    is_peak     = 1'b1;
    for (int i = 0; i < WINDOW_LEN; i++) begin
      if (hist_val_q[i] > center) is_peak = 1'b0;
    end
    // Older side is strict so a plateau reports its oldest sample.
    for (int i = WINDOW_LEN + 1; i < L; i++) begin
      if (hist_val_q[i] >= center) is_peak = 1'b0;
    end
    if (TH_W'(center) <= thresh) is_peak = 1'b0;
    if (center < min_thresh_i) is_peak = 1'b0;
  end

  logic [1:0]      state_q, state_d;
  logic [HO_W-1:0] ho_cnt_q, ho_cnt_d;
  logic            detect;

  always_comb begin
    state_d  = state_q;
    ho_cnt_d = ho_cnt_q;
    detect   = 1'b0;
    if (shifted_q) begin
      case (state_q)
        ST_FILL: begin
          if (fill_cnt_q == FILL_W'(N_FILL)) state_d = ST_SEARCH;
        end
        ST_SEARCH: begin
          if (is_peak) begin
            detect   = 1'b1;
            state_d  = ST_HOLD;
            ho_cnt_d = HO_W'(HOLDOFF);
          end
        end
        ST_HOLD: begin
          // The sample that empties the counter is consumed, not evaluated.
          ho_cnt_d = ho_cnt_q - HO_W'(1);
          if (ho_cnt_q == HO_W'(1)) state_d = ST_SEARCH;
        end
        default: state_d = ST_FILL;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q          <= ST_FILL;
      ho_cnt_q         <= '0;
      peak_detected_o  <= 1'b0;
      peak_nid2_o      <= '0;
      peak_value_o     <= '0;
      peak_timestamp_o <= '0;
    end else begin
      state_q         <= state_d;
      ho_cnt_q        <= ho_cnt_d;
      peak_detected_o <= detect;
      if (detect) begin
        peak_nid2_o      <= hist_ch_q[WINDOW_LEN];
        peak_value_o     <= hist_val_q[WINDOW_LEN];
        peak_timestamp_o <= hist_ts_q[WINDOW_LEN];
      end
    end
  end

endmodule
